enemy_hit_detector: RTL and testbench

Consumer of the enemy formation's position: resolves a player-missile coordinate against the moving alien grid, owns the per-alien alive bitmap, and answers each shot with hit/miss plus the struck cell. It sits between the missile logic, which issues shots, and the formation controller, which supplies the formation's left/upper edges. It also feeds the renderer (alive bitmap) and the score/game-over logic (hit pulse, alive count, all-dead flag).

---
 rtl/enemy_hit_detector_pkg.sv | 16 +
 rtl/enemy_hit_detector_if.sv | 13 +
 rtl/enemy_hit_detector_cell_locator.sv | 32 +++
 rtl/enemy_hit_detector.sv | 120 ++++++++++++
 tb/tb_enemy_hit_detector.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/enemy_hit_detector_pkg.sv
// space_invaders_pkg: grid geometry shared by the formation controller, renderer and hit detector.
package space_invaders_pkg;
    localparam int COLS     = 11;
    localparam int ROWS     = 5;
    localparam int CELL_W   = 44;
    localparam int CELL_H   = 28;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 16;
    localparam int N_ALIENS = COLS * ROWS;
    localparam int POS_W    = 10;
    localparam int COL_W    = $clog2(COLS);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int IDX_W    = $clog2(N_ALIENS);
    localparam int CNT_W    = $clog2(N_ALIENS + 1);
    typedef enum logic [2:0] {IDLE, RANGE, DIV_X, DIV_Y, CHECK, RESP, WAIT_LOW} hit_state_t;
endpackage

// File: rtl/enemy_hit_detector_if.sv
// enemy_hit_detector_if: shot request/response handshake between missile logic and hit detector.
interface enemy_hit_detector_if;
    import space_invaders_pkg::*;
    logic             shot_req;
    logic [POS_W-1:0] shot_x;
    logic [POS_W-1:0] shot_y;
    logic             shot_ack;
    logic             hit;
    logic [COL_W-1:0] hit_col;
    logic [ROW_W-1:0] hit_row;
    modport master (output shot_req, shot_x, shot_y, input shot_ack, hit, hit_col, hit_row);
    modport slave  (input shot_req, shot_x, shot_y, output shot_ack, hit, hit_col, hit_row);
endinterface

// File: rtl/enemy_hit_detector_cell_locator.sv
// cell_locator: iterative subtract-divider; one subtraction per cycle after start, done once remainder < divisor.
module cell_locator #(
    parameter int W  = 10,
    parameter int QW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [W-1:0]  dividend_i,
    input  logic [W-1:0]  divisor_i,
    output logic [QW-1:0] quotient_o,
    output logic [W-1:0]  remainder_o,
    output logic          done_o
);
    logic [W-1:0]  rem_q;
    logic [QW-1:0] quo_q;
    assign done_o      = rem_q < divisor_i;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (start_i) begin
            rem_q <= dividend_i;
            quo_q <= '0;
        end else if (!done_o) begin
            rem_q <= rem_q - divisor_i;
            quo_q <= quo_q + QW'(1);
        end
    end
endmodule

// File: rtl/enemy_hit_detector.sv
// enemy_hit_detector: resolves a missile position against the moving alien grid
// and owns the alive bitmap, live count and all-dead flag.
module enemy_hit_detector
    import space_invaders_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [POS_W-1:0]    l_edge_i,
    input  logic [POS_W-1:0]    u_edge_i,
    enemy_hit_detector_if.slave shot,
    output logic [N_ALIENS-1:0] alive_o,
    output logic [CNT_W-1:0]    alive_count_o,
    output logic                all_dead_o
);
    localparam logic [POS_W-1:0] GRID_X = POS_W'(COLS * CELL_W);
    localparam logic [POS_W-1:0] GRID_Y = POS_W'(ROWS * CELL_H);
    hit_state_t          state_q, state_d;
    logic [POS_W-1:0]    sx_q, sy_q, le_q, ue_q;
    logic signed [POS_W:0] dx, dy;
    logic                in_grid, ld_x, ld_y, done_x, done_y, hit_d;
    logic [COL_W-1:0]    qx;
    logic [ROW_W-1:0]    qy;
    logic [POS_W-1:0]    rx, ry;
    logic [IDX_W-1:0]    idx;
    logic [N_ALIENS-1:0] alive_q;
    logic [CNT_W-1:0]    count_q;
    logic                dead_q, ack_q, hit_q;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;

    // 11-bit signed offsets so a missile left of / above the formation reads as negative
    assign dx      = $signed({1'b0, sx_q}) - $signed({1'b0, le_q});
    assign dy      = $signed({1'b0, sy_q}) - $signed({1'b0, ue_q});
    assign in_grid = !dx[POS_W] && !dy[POS_W] && dx[POS_W-1:0] < GRID_X && dy[POS_W-1:0] < GRID_Y;
    assign ld_x    = state_q == RANGE && in_grid;
    assign ld_y    = state_q == DIV_X && done_x;
    assign idx     = IDX_W'(int'(qy) * COLS + int'(qx));
    assign hit_d   = rx < POS_W'(SPRITE_W) && ry < POS_W'(SPRITE_H) && alive_q[idx];

    cell_locator #(.W(POS_W), .QW(COL_W)) u_loc_x (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(ld_x),
        .dividend_i(dx[POS_W-1:0]), .divisor_i(POS_W'(CELL_W)),
        .quotient_o(qx), .remainder_o(rx), .done_o(done_x)
    );
    cell_locator #(.W(POS_W), .QW(ROW_W)) u_loc_y (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(ld_y),
        .dividend_i(dy[POS_W-1:0]), .divisor_i(POS_W'(CELL_H)),
        .quotient_o(qy), .remainder_o(ry), .done_o(done_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = shot.shot_req ? RANGE : IDLE;
            RANGE:    state_d = in_grid ? DIV_X : RESP;
            DIV_X:    state_d = done_x ? DIV_Y : DIV_X;
            DIV_Y:    state_d = done_y ? CHECK : DIV_Y;
            CHECK:    state_d = RESP;
            RESP:     state_d = WAIT_LOW;
            WAIT_LOW: state_d = shot.shot_req ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            alive_q <= '0;
            count_q <= '0;
            dead_q  <= 1'b0;
            ack_q   <= 1'b0;
            hit_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            le_q    <= '0;
            ue_q    <= '0;
        end else if (start_i) begin
            state_q <= IDLE;
            alive_q <= '1;
            count_q <= CNT_W'(N_ALIENS);
            dead_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= state_d == RESP;
            if (state_q == IDLE && shot.shot_req) begin
                sx_q <= shot.shot_x;
                sy_q <= shot.shot_y;
                le_q <= l_edge_i;
                ue_q <= u_edge_i;
            end
            if (state_q == RANGE && !in_grid) begin
                hit_q <= 1'b0;
                col_q <= '0;
                row_q <= '0;
            end
            if (state_q == CHECK) begin
                hit_q <= hit_d;
                col_q <= qx;
                row_q <= qy;
                if (hit_d) begin
                    alive_q[idx] <= 1'b0;
                    count_q      <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) dead_q <= 1'b1;
                end
            end
        end
    end

    assign shot.shot_ack = ack_q;
    assign shot.hit      = hit_q;
    assign shot.hit_col  = col_q;
    assign shot.hit_row  = row_q;
    assign alive_o       = alive_q;
    assign alive_count_o = count_q;
    assign all_dead_o    = dead_q;
endmodule

// File: tb/tb_enemy_hit_detector.sv
// tb_enemy_hit_detector: directed shots with a response scoreboard checked by an ack monitor.
module tb_enemy_hit_detector;
    import space_invaders_pkg::*;

    typedef struct {
        logic hit;
        int   col, row, cnt, dead, e0, lat;
    } exp_t;

    logic                clk = 0, rst = 1, start = 0;
    logic [POS_W-1:0]    l_edge = 10'd100, u_edge = 10'd40;
    logic [N_ALIENS-1:0] alive;
    logic [CNT_W-1:0]    alive_count;
    logic                all_dead;
    int                  vectors = 0, miscompares = 0, cyc = 0, ack_total = 0;
    exp_t                sb[$];
    logic [N_ALIENS-1:0] m_alive = '0;
    int                  m_cnt = 0, m_dead = 0;

    enemy_hit_detector_if shot_if();

    enemy_hit_detector dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .l_edge_i(l_edge), .u_edge_i(u_edge), .shot(shot_if),
        .alive_o(alive), .alive_count_o(alive_count), .all_dead_o(all_dead)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (shot_if.shot_ack === 1'b1) begin
            exp_t e;
            ack_total++;
            if (sb.size() == 0) check("unexpected_ack", 1, 0);
            else begin
                e = sb.pop_front();
                check("hit", 64'(shot_if.hit), 64'(e.hit));
                check("hit_col", 64'(shot_if.hit_col), 64'(e.col));
                check("hit_row", 64'(shot_if.hit_row), 64'(e.row));
                check("alive_count", 64'(alive_count), 64'(e.cnt));
                check("all_dead", 64'(all_dead), 64'(e.dead));
                check("latency", 64'(cyc - e.e0), 64'(e.lat));
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        m_alive = '1;
        m_cnt = N_ALIENS;
        m_dead = 0;
    endtask

    task automatic shoot(input int x, input int y, input bit eh, input int ec, input int er,
                         input int el, input int hold);
        exp_t e;
        int   a0;
        bit   got;
        @(negedge clk);
        shot_if.shot_x = 10'(x);
        shot_if.shot_y = 10'(y);
        shot_if.shot_req = 1;
        if (eh) begin
            m_alive[er * COLS + ec] = 1'b0;
            m_cnt--;
            if (m_cnt == 0) m_dead = 1;
        end
        e = '{eh, ec, er, m_cnt, m_dead, cyc + 1, el};
        sb.push_back(e);
        a0 = ack_total;
        got = 0;
        @(posedge clk);
        #1;
        l_edge = 10'($urandom);
        u_edge = 10'($urandom);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            got = ack_total != a0;
        end
        if (!got) begin
            check("ack_timeout", 0, 1);
            void'(sb.pop_front());
        end
        repeat (hold) @(negedge clk);
        #1;
        shot_if.shot_req = 0;
        l_edge = 10'd100;
        u_edge = 10'd40;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a0;
        shot_if.shot_req = 0;
        shot_if.shot_x = '0;
        shot_if.shot_y = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_alive", 64'(alive), 0);
        check("rst_count", 64'(alive_count), 0);
        check("rst_all_dead", 64'(all_dead), 0);
        check("rst_ack", 64'(shot_if.shot_ack), 0);
        check("rst_hit", 64'(shot_if.hit), 0);
        check("rst_col", 64'(shot_if.hit_col), 0);
        check("rst_row", 64'(shot_if.hit_row), 0);

        shoot(100, 40, 0, 0, 0, 4, 0);
        do_start();
        check("start_alive", 64'(alive), 64'(m_alive));
        check("start_count", 64'(alive_count), 55);

        shoot(100, 40, 1, 0, 0, 4, 0);
        check("alive0_cleared", 64'(alive), 64'(m_alive));
        shoot(100, 40, 0, 0, 0, 4, 0);
        shoot(545, 155, 1, 10, 4, 18, 0);
        check("alive54_cleared", 64'(alive), 64'(m_alive));
        shoot(584, 40, 0, 0, 0, 1, 0);
        shoot(583, 40, 0, 10, 0, 14, 0);
        shoot(135, 40, 0, 0, 0, 4, 0);
        shoot(99, 40, 0, 0, 0, 1, 0);
        shoot(100, 179, 0, 0, 4, 8, 0);
        shoot(100, 180, 0, 0, 0, 1, 0);
        shoot(263, 111, 1, 3, 2, 9, 0);

        a0 = ack_total;
        shoot(100, 40, 0, 0, 0, 4, 30);
        check("held_req_single_ack", 64'(ack_total - a0), 1);
        shoot(144, 40, 1, 1, 0, 5, 0);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                shoot(100 + c * 44 + 1, 40 + r * 28 + 1, m_alive[r * COLS + c], c, r, 4 + c + r, 0);
        check("cleared_count", 64'(alive_count), 0);
        check("cleared_all_dead", 64'(all_dead), 1);
        check("cleared_alive", 64'(alive), 0);

        @(negedge clk);
        shot_if.shot_x = 10'd540;
        shot_if.shot_y = 10'd40;
        shot_if.shot_req = 1;
        a0 = ack_total;
        repeat (4) @(negedge clk);
        start = 1;
        shot_if.shot_req = 0;
        @(negedge clk);
        start = 0;
        m_alive = '1;
        m_cnt = N_ALIENS;
        m_dead = 0;
        repeat (25) @(negedge clk);
        check("abort_no_ack", 64'(ack_total - a0), 0);
        check("abort_alive", 64'(alive), 64'(m_alive));
        check("abort_count", 64'(alive_count), 55);
        check("abort_all_dead", 64'(all_dead), 0);

        shoot(100, 40, 1, 0, 0, 4, 0);
        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
